// File: rtl/dr_beam_packer_if.sv
// Bus bundle for dr_beam_packer: 4-lane PRB-framed receive stream in,
// 16-lane packed words and error status out.
interface dr_beam_packer_if #(
    parameter int LANE_W = 32
);
    logic [3:0][LANE_W-1:0]  i_rx_data;
    logic                    i_rx_vld;
    logic                    i_rx_sop;
    logic                    i_rx_eop;
    logic [8:0]              i_prb_idx;

    logic [15:0][LANE_W-1:0] o_tx_data;
    logic                    o_tx_vld;
    logic                    o_tx_sop;
    logic                    o_tx_eop;
    logic [8:0]              o_prb_idx;
    logic                    o_err_framing;
    logic                    o_err_prb;
    logic [15:0]             o_err_cnt;

    modport master (
        output i_rx_data, i_rx_vld, i_rx_sop, i_rx_eop, i_prb_idx,
        input  o_tx_data, o_tx_vld, o_tx_sop, o_tx_eop, o_prb_idx,
        input  o_err_framing, o_err_prb, o_err_cnt
    );

    modport slave (
        input  i_rx_data, i_rx_vld, i_rx_sop, i_rx_eop, i_prb_idx,
        output o_tx_data, o_tx_vld, o_tx_sop, o_tx_eop, o_prb_idx,
        output o_err_framing, o_err_prb, o_err_cnt
    );
endinterface

// File: rtl/dr_beam_packer.sv
// Receive-side beam packer: checks RE/RB/PRB framing on the 4-lane stream and
// packs every 4 beats into one 16-lane word for the 16-beam compute stage.
//
// state | meaning
// HUNT  | waiting for a sop beat; non-sop beats are dropped silently
// RUN   | locked to framing; packing beats and checking sop/eop/PRB index
module dr_beam_packer #(
    parameter int LANE_W     = 32,
    parameter int RE_PER_PRB = 12,
    parameter int RB_GRP     = 4,
    parameter int PRB_NUM    = 132
) (
    input  logic           i_clk,
    input  logic           i_reset_n,
    dr_beam_packer_if.slave bus
);
    localparam int RE_W = (RE_PER_PRB > 1) ? $clog2(RE_PER_PRB) : 1;
    localparam int RB_W = (RB_GRP > 1) ? $clog2(RB_GRP) : 1;
    localparam logic [RE_W-1:0] RE_LAST  = RE_W'(RE_PER_PRB - 1);
    localparam logic [RB_W-1:0] RB_LAST  = RB_W'(RB_GRP - 1);
    localparam logic [8:0]      PRB_LAST = 9'(PRB_NUM - 1);

    typedef enum logic {HUNT = 1'b0, RUN = 1'b1} state_t;

    logic rst_meta, rst_sync_n;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rst_meta   <= 1'b0;
            rst_sync_n <= 1'b0;
        end else begin
            rst_meta   <= 1'b1;
            rst_sync_n <= rst_meta;
        end
    end

    state_t                       state;
    logic [RE_W-1:0]              re_cnt;
    logic [RB_W-1:0]              rb_cnt;
    logic [8:0]                   exp_prb;
    logic [2:0][3:0][LANE_W-1:0]  stage;
    logic                         word_sop;
    logic [8:0]                   word_prb;

    logic [15:0][LANE_W-1:0]      tx_data;
    logic                         tx_vld, tx_sop, tx_eop;
    logic [8:0]                   tx_prb;
    logic                         err_framing, err_prb;
    logic [15:0]                  err_cnt;

    logic [1:0]  slot;
    logic        at_last, grp_start, run_beat;
    logic        frame_err, prb_err, resync;
    logic [16:0] err_sum;

    always_comb begin
        slot      = re_cnt[1:0];
        at_last   = (re_cnt == RE_LAST);
        grp_start = (re_cnt == '0) && (rb_cnt == '0);
        run_beat  = (state == RUN) && bus.i_rx_vld;
        frame_err = run_beat && ((bus.i_rx_eop != at_last) || (bus.i_rx_sop != grp_start));
        prb_err   = run_beat && (bus.i_prb_idx != exp_prb);
        // A sop beat either starts lock from HUNT or re-locks on the beat that broke framing
        resync    = bus.i_rx_vld && bus.i_rx_sop && ((state == HUNT) || frame_err);
        err_sum   = {1'b0, err_cnt} + 17'(frame_err) + 17'(prb_err);
    end

    always_ff @(posedge i_clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state       <= HUNT;
            re_cnt      <= '0;
            rb_cnt      <= '0;
            exp_prb     <= '0;
            stage       <= '0;
            word_sop    <= 1'b0;
            word_prb    <= '0;
            tx_data     <= '0;
            tx_vld      <= 1'b0;
            tx_sop      <= 1'b0;
            tx_eop      <= 1'b0;
            tx_prb      <= '0;
            err_framing <= 1'b0;
            err_prb     <= 1'b0;
            err_cnt     <= '0;
        end else begin
            tx_vld      <= 1'b0;
            tx_sop      <= 1'b0;
            tx_eop      <= 1'b0;
            tx_prb      <= '0;
            err_framing <= frame_err;
            err_prb     <= prb_err;
            err_cnt     <= err_sum[16] ? 16'hFFFF : err_sum[15:0];

            if (resync) begin
                state    <= RUN;
                re_cnt   <= RE_W'(1);
                rb_cnt   <= '0;
                exp_prb  <= bus.i_prb_idx;
                stage[0] <= bus.i_rx_data;
                word_sop <= 1'b1;
                word_prb <= bus.i_prb_idx;
            end else if (frame_err) begin
                state <= HUNT;
            end else if (run_beat) begin
                case (slot)
                    2'd0: begin
                        stage[0] <= bus.i_rx_data;
                        word_sop <= bus.i_rx_sop;
                        word_prb <= exp_prb;
                    end
                    2'd1: stage[1] <= bus.i_rx_data;
                    2'd2: stage[2] <= bus.i_rx_data;
                    default: begin
                        tx_data <= {bus.i_rx_data, stage};
                        tx_vld  <= 1'b1;
                        tx_sop  <= word_sop;
                        tx_eop  <= bus.i_rx_eop;
                        tx_prb  <= word_prb;
                    end
                endcase

                if (bus.i_rx_eop) begin
                    re_cnt  <= '0;
                    rb_cnt  <= (rb_cnt == RB_LAST) ? '0 : rb_cnt + 1'b1;
                    exp_prb <= (exp_prb == PRB_LAST) ? '0 : exp_prb + 1'b1;
                end else begin
                    re_cnt <= re_cnt + 1'b1;
                end
            end
        end
    end

    assign bus.o_tx_data     = tx_data;
    assign bus.o_tx_vld      = tx_vld;
    assign bus.o_tx_sop      = tx_sop;
    assign bus.o_tx_eop      = tx_eop;
    assign bus.o_prb_idx     = tx_prb;
    assign bus.o_err_framing = err_framing;
    assign bus.o_err_prb     = err_prb;
    assign bus.o_err_cnt     = err_cnt;
endmodule

// File: tb/tb_dr_beam_packer.sv
// Bench for dr_beam_packer: per-cycle comparison against a beat-level model,
// plus literal expectations for each directed scenario.
module tb_dr_beam_packer;
    localparam int LANE_W = 32;
    localparam int RE     = 12;
    localparam int GRP    = 4;
    localparam int PNUM   = 132;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    dr_beam_packer_if #(.LANE_W(LANE_W)) bus ();

    dr_beam_packer #(
        .LANE_W(LANE_W), .RE_PER_PRB(RE), .RB_GRP(GRP), .PRB_NUM(PNUM)
    ) dut (
        .i_clk(clk), .i_reset_n(rst_n), .bus(bus)
    );

    int n_checks = 0;
    int n_err    = 0;
    logic chk_en = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- beat-level model ----------------
    int   m_hunt, m_re, m_rb, m_eprb, m_wprb;
    logic m_wsop;
    logic [31:0] m_lane [16];
    logic e_vld, e_sop, e_eop, e_fr, e_pe;
    int   e_prb, e_cnt;
    logic [15:0][31:0] e_data;

    task automatic model_reset();
        m_hunt = 1; m_re = 0; m_rb = 0; m_eprb = 0; m_wprb = 0; m_wsop = 1'b0;
        for (int i = 0; i < 16; i++) m_lane[i] = '0;
        e_vld = 0; e_sop = 0; e_eop = 0; e_fr = 0; e_pe = 0; e_prb = 0; e_cnt = 0;
        e_data = '0;
    endtask

    task automatic model_start(input logic [3:0][31:0] d, input int p);
        m_hunt = 0; m_re = 1; m_rb = 0; m_eprb = p; m_wsop = 1'b1; m_wprb = p;
        for (int j = 0; j < 4; j++) m_lane[j] = d[j];
    endtask

    task automatic model_step();
        logic [3:0][31:0] d;
        logic s, e;
        int p, sl;
        e_vld = 0; e_sop = 0; e_eop = 0; e_prb = 0; e_fr = 0; e_pe = 0;
        if (bus.i_rx_vld) begin
            d = bus.i_rx_data; s = bus.i_rx_sop; e = bus.i_rx_eop; p = int'(bus.i_prb_idx);
            if (m_hunt != 0) begin
                if (s) model_start(d, p);
            end else begin
                e_pe = (p != m_eprb);
                if ((e != (m_re == RE - 1)) || (s != (m_re == 0 && m_rb == 0))) begin
                    e_fr = 1;
                    if (s) model_start(d, p);
                    else m_hunt = 1;
                end else begin
                    sl = m_re % 4;
                    for (int j = 0; j < 4; j++) m_lane[4 * sl + j] = d[j];
                    if (sl == 0) begin m_wsop = s; m_wprb = m_eprb; end
                    if (sl == 3) begin
                        e_vld = 1; e_sop = m_wsop; e_eop = e; e_prb = m_wprb;
                        for (int i = 0; i < 16; i++) e_data[i] = m_lane[i];
                    end
                    if (e) begin
                        m_re = 0; m_rb = (m_rb + 1) % GRP; m_eprb = (m_eprb + 1) % PNUM;
                    end else begin
                        m_re = m_re + 1;
                    end
                end
            end
            e_cnt = e_cnt + int'(e_fr) + int'(e_pe);
            if (e_cnt > 65535) e_cnt = 65535;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    // ---------------- per-cycle compare ----------------
    typedef struct {
        logic [15:0][31:0] d;
        logic s;
        logic e;
        int   p;
    } word_t;
    word_t got[$];
    int n_fr = 0;
    int n_pe = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("tx_vld", bus.o_tx_vld, e_vld);
                chk("tx_sop", bus.o_tx_sop, e_sop);
                chk("tx_eop", bus.o_tx_eop, e_eop);
                chk("prb_idx", bus.o_prb_idx, e_prb);
                chk("err_framing", bus.o_err_framing, e_fr);
                chk("err_prb", bus.o_err_prb, e_pe);
                chk("err_cnt", bus.o_err_cnt, e_cnt);
                n_checks++;
                if (bus.o_tx_data !== e_data) begin
                    n_err++;
                    $display("FAIL tx_data: got %h expected %h", bus.o_tx_data, e_data);
                end
                if (bus.o_tx_vld) got.push_back('{bus.o_tx_data, bus.o_tx_sop, bus.o_tx_eop, int'(bus.o_prb_idx)});
                if (bus.o_err_framing) n_fr++;
                if (bus.o_err_prb) n_pe++;
            end
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [3:0][31:0] lanes_of(input int b);
        logic [3:0][31:0] r;
        for (int j = 0; j < 4; j++) r[j] = 32'((b << 8) | j);
        return r;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic beat(input int b, input logic s, input logic e, input int p);
        bus.i_rx_data = lanes_of(b);
        bus.i_rx_sop  = s;
        bus.i_rx_eop  = e;
        bus.i_prb_idx = 9'(p);
        bus.i_rx_vld  = 1'b1;
        @(posedge clk); #1;
        bus.i_rx_vld = 1'b0;
        bus.i_rx_sop = 1'b0;
        bus.i_rx_eop = 1'b0;
    endtask

    task automatic send_group(input int start_prb, input int base, input int gapmax,
                              input int bad_p, input int bad_val);
        for (int p = 0; p < GRP; p++) begin
            for (int r = 0; r < RE; r++) begin
                beat(base + p * RE + r, (p == 0) && (r == 0), r == RE - 1,
                     (p == bad_p) ? bad_val : (start_prb + p) % PNUM);
                if (gapmax > 0) idle(int'($urandom_range(0, gapmax)));
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.i_rx_vld = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(4);
        got.delete();
        n_fr = 0;
        n_pe = 0;
    endtask

    // Literal expectations for one clean 4-PRB group starting at PRB 0
    task automatic check_nominal(input string tag, input int base, input int first);
        for (int n = 0; n < 12; n++) begin
            if (first + n < got.size()) begin
                chk({tag, "_sop"}, got[first + n].s, (n == 0) ? 1 : 0);
                chk({tag, "_eop"}, got[first + n].e, (n % 3 == 2) ? 1 : 0);
                chk({tag, "_prb"}, got[first + n].p, n / 3);
                chk({tag, "_lane13"}, int'(got[first + n].d[13]), ((base + 4 * n + 3) << 8) | 1);
                chk({tag, "_lane0"}, int'(got[first + n].d[0]), (base + 4 * n) << 8);
            end
        end
    endtask

    initial begin
        bus.i_rx_data = '0;
        bus.i_rx_vld  = 1'b0;
        bus.i_rx_sop  = 1'b0;
        bus.i_rx_eop  = 1'b0;
        bus.i_prb_idx = '0;
        #1 rst_n = 1'b0;
        #1 chk_en = 1'b1;
        @(posedge clk); #1;
        do_reset();

        chk("reset_vld", bus.o_tx_vld, 0);
        chk("reset_cnt", bus.o_err_cnt, 0);
        chk("reset_data0", int'(bus.o_tx_data[0]), 0);

        // nominal continuous group
        send_group(0, 0, 0, -1, 0);
        idle(3);
        chk("nom_words", got.size(), 12);
        chk("nom_err_cnt", bus.o_err_cnt, 0);
        check_nominal("nom", 0, 0);

        // same stream with random gaps
        do_reset();
        send_group(0, 0, 5, -1, 0);
        idle(3);
        chk("gap_words", got.size(), 12);
        chk("gap_err_cnt", bus.o_err_cnt, 0);
        check_nominal("gap", 0, 0);

        // early eop on beat 7 of PRB 0, junk, then a clean group
        do_reset();
        for (int b = 0; b < 8; b++) beat(b, b == 0, b == 7, 0);
        idle(2);
        chk("early_fr_pulses", n_fr, 1);
        chk("early_cnt", bus.o_err_cnt, 1);
        chk("early_words", got.size(), 1);
        for (int b = 0; b < 5; b++) beat(100 + b, 1'b0, 1'b0, 0);
        send_group(0, 200, 0, -1, 0);
        idle(3);
        chk("early_words_after", got.size(), 13);
        chk("early_cnt_after", bus.o_err_cnt, 1);
        check_nominal("early", 200, 1);

        // PRB index mismatch during the second PRB
        do_reset();
        send_group(0, 0, 0, 1, 5);
        idle(3);
        chk("prb_pulses", n_pe, 12);
        chk("prb_fr_pulses", n_fr, 0);
        chk("prb_cnt", bus.o_err_cnt, 12);
        chk("prb_words", got.size(), 12);
        check_nominal("prb", 0, 0);

        // async reset two beats into a word, while outputs are non-zero
        beat(300, 1'b1, 1'b0, 0);
        beat(301, 1'b0, 1'b0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_vld", bus.o_tx_vld, 0);
        chk("arst_cnt", bus.o_err_cnt, 0);
        chk("arst_data15", int'(bus.o_tx_data[15]), 0);
        idle(2);
        rst_n = 1'b1;
        idle(4);
        got.delete();
        send_group(0, 400, 0, -1, 0);
        idle(3);
        chk("arst_words", got.size(), 12);
        chk("arst_cnt_after", bus.o_err_cnt, 0);
        check_nominal("arst", 400, 0);

        // PRB index wrap 128..131 then 0..3
        do_reset();
        send_group(128, 0, 0, -1, 0);
        send_group(0, 48, 0, -1, 0);
        idle(3);
        chk("wrap_words", got.size(), 24);
        chk("wrap_cnt", bus.o_err_cnt, 0);
        if (got.size() == 24) begin
            chk("wrap_prb_w0", got[0].p, 128);
            chk("wrap_prb_w11", got[11].p, 131);
            chk("wrap_prb_w12", got[12].p, 0);
            chk("wrap_sop_w12", got[12].s, 1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/dr_beam_packer.md
# dr_beam_packer

Receive-side counterpart of the dimension-reduction data buffer. It consumes the 4-lane, PRB-framed stream (4 × 32-bit lanes, sop/eop, PRB index) and re-packs every 4 consecutive beats into one 16-lane word. It also checks RE/RB/PRB framing, then forwards the wide words to the downstream 16-beam compute stage. It has no backpressure: the input may contain valid gaps, and the output is valid-only.

## Interface
Parameters:
- LANE_W, 32, bits per lane
- RE_PER_PRB, 12, beats per PRB (must be a multiple of 4)
- RB_GRP, 4, PRBs per sop group
- PRB_NUM, 132, PRB index wraps to 0 after PRB_NUM-1

Ports:
- i_clk  in  1  single clock
- i_reset_n  in  1  asynchronous, active-low reset
- i_rx_data  in  [3:0][LANE_W-1:0]  input lanes
- i_rx_vld  in  1  beat valid
- i_rx_sop  in  1  first beat of an RB group (qualified by vld)
- i_rx_eop  in  1  last beat of a PRB (qualified by vld)
- i_prb_idx  in  9  PRB index of the current beat
- o_tx_data  out  [15:0][LANE_W-1:0]  packed word
- o_tx_vld  out  1  word valid
- o_tx_sop  out  1  word holds an input sop beat
- o_tx_eop  out  1  word holds an input eop beat
- o_prb_idx  out  9  PRB index of the word
- o_err_framing  out  1  one-cycle pulse on a framing error
- o_err_prb  out  1  one-cycle pulse on a PRB index mismatch
- o_err_cnt  out  16  total errors since reset, saturating at 0xFFFF

## Operation
- **Counters:** re_cnt 0..RE_PER_PRB-1, rb_cnt 0..RB_GRP-1, exp_prb 0..PRB_NUM-1. slot = re_cnt[1:0]. All counters advance only on i_rx_vld; they hold during gaps.
- **FSM states:** HUNT, RUN. Reset state is HUNT.
- **HUNT:**
  - Beats without sop are discarded and raise no error.
  - A beat with sop sets re_cnt=0, rb_cnt=0, exp_prb=i_prb_idx, stores the beat in slot 0, and moves to RUN.
- **RUN, each valid beat:**
  - Lanes go to wide-word lanes 4·slot+j, j=0..3.
  - re_cnt increments; it wraps to 0 on an accepted eop.
- **PRB check:** i_prb_idx != exp_prb pulses o_err_prb. The beat is still packed and the FSM stays in RUN.
- **Accepted eop:** rb_cnt increments modulo RB_GRP, and exp_prb increments modulo PRB_NUM.
- **Framing errors** (each pulses o_err_framing, discards the partial word, and returns to HUNT):
  - eop with re_cnt != RE_PER_PRB-1
  - no eop at re_cnt == RE_PER_PRB-1
  - sop with (re_cnt,rb_cnt) != (0,0)
  - no sop at (re_cnt,rb_cnt) == (0,0)
- **Re-sync:** if the erroring beat carries sop, HUNT handling is applied to that beat in the same cycle. The block therefore re-syncs without losing the beat.
- **Word emission:** a word is emitted when slot 3 is written.
  - o_tx_sop = the word's slot-0 beat had sop.
  - o_tx_eop = the slot-3 beat had eop.
  - o_prb_idx = exp_prb at the slot-0 beat.
- **o_err_cnt:** +1 per framing error, +1 per PRB error, +2 if both occur in the same cycle. Saturates at 0xFFFF.
- **Arithmetic:** exp_prb compare is 9-bit unsigned, and wrap is explicit at PRB_NUM-1 (not 2^9).

## Timing
- **Reset values:** all outputs 0, FSM = HUNT, counters 0. Reset is asynchronous on assertion and released synchronously through a 2-flop reset synchronizer.
- **Latency:** o_tx_vld rises exactly 1 cycle after the valid beat that fills slot 3.
- **Output hold:** o_tx_data holds its last value while o_tx_vld=0. o_tx_sop, o_tx_eop and o_prb_idx are 0 whenever o_tx_vld=0.
- **Error pulses:** o_err_framing and o_err_prb are registered, asserted 1 cycle after the offending beat, for one cycle.
- **Word rate:** with continuous input, output is one word every 4 cycles, giving 3 words per PRB.
- **Valid gaps:** any number of idle cycles between beats, including inside a word, leaves contents and counters intact.
- **Reset mid-word:** the partial word is dropped and no o_tx_vld is issued.
- **exp_prb wrap:** after an accepted eop at PRB_NUM-1, exp_prb = 0; no error if the next PRB is index 0.

## Test plan
- **Nominal group:** continuous 4 PRBs (48 beats, lane value = beat number, prb 0..3, sop on beat 0, eop on beats 11/23/35/47).
  - Expect 12 words, each word's lanes 4k..4k+3 = beat 4n+k.
  - o_tx_sop only on word 0; o_tx_eop on words 2/5/8/11; o_prb_idx 0,0,0,1,…,3.
  - Zero errors.
- **Random gaps:** same stream with random 0–5-cycle vld gaps. Expect identical words, each 1 cycle after its 4th beat.
- **Early eop:** eop on beat 7 of PRB 0.
  - Expect o_err_framing pulse, o_err_cnt=1, no word 2.
  - Beats ignored until the next sop; a clean group afterwards is packed correctly.
- **PRB mismatch:** prb_idx 5 during the second PRB (expected 1). Expect o_err_prb for each of its 12 beats, o_err_cnt=12, all words still emitted.
- **Index wrap:** PRBs 128..131 then 0..3. Expect no errors; o_prb_idx wraps 131→0.
- **Async reset mid-word:** assert reset after 2 beats. Expect immediate 0 outputs, no word; the next sop group is packed from slot 0.
